// File: rtl/fpu_issue.sv
// FPU issue stage: registers RV32F instructions onto the FPU bus and stalls on RAW hazards
// against an age-indexed scoreboard. Optional FPU_WB_BYPASS_EN assumes a write-through regfile.
module fpu_issue #(
  parameter int WB_LAT = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_in,
  input  logic             inst_valid,
  output logic             inst_ready,
  output logic [31:0]      inst_out,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: inst_in is taken on a rising edge where inst_valid && inst_ready;
  // inst_ready depends only on inst_in and the scoreboard, never on inst_valid.

  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_FSW = 7'b0100111;
  localparam logic [6:0] OP_FP  = 7'b1010011;

`ifdef FPU_WB_BYPASS_EN
  localparam int HAZ_DEPTH = WB_LAT - 1;
`else
  localparam int HAZ_DEPTH = WB_LAT;
`endif

  logic [6:0] opcode;
  logic [4:0] funct5;
  logic [4:0] rs1, rs2, rd;
  logic       uses_rs1, uses_rs2, writes_freg;
  logic       hazard, accept;

  logic [WB_LAT-1:0] sb_v_q, sb_v_d;
  logic [4:0]        sb_rd_q [WB_LAT];
  logic [4:0]        sb_rd_d [WB_LAT];
  logic [31:0]       inst_out_q, inst_out_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Fields the decoder does not look at (rm/width and fmt bits).
  logic unused_fields;
  assign unused_fields = ^{inst_in[26:25], inst_in[14:12]};

  assign opcode = inst_in[6:0];
  assign funct5 = inst_in[31:27];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];
  assign rd     = inst_in[11:7];

  always_comb begin
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    writes_freg = 1'b0;
    case (opcode)
      OP_FLW: writes_freg = 1'b1;
      OP_FSW: uses_rs2 = 1'b1;
      OP_FP: begin
        case (funct5)
          5'b00000, 5'b00001, 5'b00010: begin
            uses_rs1    = 1'b1;
            uses_rs2    = 1'b1;
            writes_freg = 1'b1;
          end
          5'b11000: uses_rs1 = 1'b1;
          5'b11010: writes_freg = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // With write-through, the oldest tracked entry commits this cycle and is already readable.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_v_q[i] && ((uses_rs1 && (sb_rd_q[i] == rs1)) ||
                        (uses_rs2 && (sb_rd_q[i] == rs2)))) begin
        hazard = 1'b1;
      end
    end
  end

  assign inst_ready = ~hazard;
  assign accept     = inst_valid & inst_ready;

  always_comb begin
    inst_out_d = accept ? inst_in : 32'h0;
    sb_v_d[0]  = accept & writes_freg;
    sb_rd_d[0] = rd;
    for (int i = 1; i < WB_LAT; i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (inst_valid && !inst_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_out_q  <= 32'h0;
      sb_v_q      <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        sb_rd_q[i] <= 5'd0;
      end
    end else begin
      inst_out_q  <= inst_out_d;
      sb_v_q      <= sb_v_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < WB_LAT; i++) begin
        sb_rd_q[i] <= sb_rd_d[i];
      end
    end
  end

  assign inst_out  = inst_out_q;
  assign busy      = |sb_v_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: directed hazard scenarios, randomized traffic against a
// register-ready-time model, mid-stream reset, and stall counter saturation.
module tb_fpu_issue;

  localparam int WB_LAT = 5;
`ifdef FPU_WB_BYPASS_EN
  localparam int WIN = WB_LAT - 1;
`else
  localparam int WIN = WB_LAT;
`endif

  localparam logic [31:0] FADD_3_1_2 = 32'h002081D3;
  localparam logic [31:0] FADD_5_6_7 = 32'h007302D3;
  localparam logic [31:0] FMUL_4_3_3 = 32'h10318253;
  localparam logic [31:0] FLW_1      = 32'h00012087;
  localparam logic [31:0] FSW_1      = 32'h00112027;
  localparam logic [31:0] FCVTSW_1   = {5'h1A, 2'b00, 5'd0, 5'd1, 3'b000, 5'd1, 7'h53};
  localparam logic [31:0] OPFP_BAD   = {5'h1F, 2'b00, 5'd1, 5'd1, 3'b000, 5'd2, 7'h53};
  localparam logic [31:0] FADD_3_3_3 = {5'h00, 2'b00, 5'd3, 5'd3, 3'b000, 5'd3, 7'h53};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] inst_in;
  logic        inst_valid, inst_ready, busy;
  logic [31:0] inst_out;
  logic [31:0] stall_cnt;

  logic [31:0] s_in, s_out;
  logic        s_valid, s_ready, s_busy;
  logic [2:0]  s_cnt;

  fpu_issue #(.WB_LAT(WB_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .busy(busy), .stall_cnt(stall_cnt)
  );

  fpu_issue #(.WB_LAT(WB_LAT), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inst_in(s_in), .inst_valid(s_valid),
    .inst_ready(s_ready), .inst_out(s_out), .busy(s_busy), .stall_cnt(s_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard / model state: cycle at which each float register may next be read
  int          passed = 0;
  int          total  = 0;
  int          free_at [32];
  int          last_acc_cyc;
  logic [31:0] last_acc_inst;
  int          last_wr;
  longint      exp_cnt;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic void fdec(input logic [31:0] i, output bit u1, output bit u2, output bit w);
    u1 = 0; u2 = 0; w = 0;
    if (i[6:0] == 7'h07) w = 1;
    else if (i[6:0] == 7'h27) u2 = 1;
    else if (i[6:0] == 7'h53) begin
      if (i[31:27] <= 5'd2) begin u1 = 1; u2 = 1; w = 1; end
      else if (i[31:27] == 5'h18) u1 = 1;
      else if (i[31:27] == 5'h1A) w = 1;
    end
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) free_at[r] = 0;
    last_acc_cyc  = -100;
    last_acc_inst = 32'h0;
    last_wr       = -100;
    exp_cnt       = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inst_out"}, 64'(inst_out), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_ready"}, 64'(inst_ready), 64'h1);
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'h0);
  endtask

  // driver: one cycle, drive at negedge, check at negedge+1, update model
  task automatic step(input bit v, input logic [31:0] ins, output bit acc);
    bit u1, u2, w, rdy, bsy;
    logic [31:0] e_out;
    @(negedge clk);
    inst_valid = v;
    inst_in    = ins;
    #1;
    fdec(ins, u1, u2, w);
    rdy = 1;
    if (u1 && free_at[ins[19:15]] > cyc) rdy = 0;
    if (u2 && free_at[ins[24:20]] > cyc) rdy = 0;
    e_out = (last_acc_cyc == cyc - 1) ? last_acc_inst : 32'h0;
    bsy = (cyc >= last_wr + 1) && (cyc <= last_wr + WB_LAT);
    chk("ready", 64'(inst_ready), 64'(rdy));
    chk("inst_out", 64'(inst_out), 64'(e_out));
    chk("busy", 64'(busy), 64'(bsy));
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    acc = v && rdy;
    if (v && !rdy && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
    if (acc) begin
      last_acc_cyc  = cyc;
      last_acc_inst = ins;
      exp_q.push_back(ins);
      if (w) begin
        free_at[ins[11:7]] = cyc + WIN + 1;
        last_wr = cyc;
      end
    end
  endtask

  task automatic issue(input logic [31:0] ins, output int stalls);
    bit acc;
    stalls = 0;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(1'b1, ins, acc);
      if (!acc) stalls++;
    end
    if (!acc) chk("issue_timeout", 64'(stalls), 64'(WIN));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, acc);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, d;
    int k;
    k = $urandom_range(0, 8);
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    case (k)
      0: return {12'($urandom), 5'($urandom), 3'b010, d, 7'h07};
      1: return {7'($urandom), b, 5'($urandom), 3'b010, 5'($urandom), 7'h27};
      2, 3, 4: return {5'(k - 2), 2'b00, b, a, 3'b000, d, 7'h53};
      5: return {5'h18, 2'b00, 5'd0, a, 3'b000, 5'($urandom), 7'h53};
      6: return {5'h1A, 2'b00, 5'd0, 5'($urandom), 3'b000, d, 7'h53};
      7: return {5'h1F, 2'b00, b, a, 3'b000, d, 7'h53};
      default: return {25'($urandom), 7'h33};
    endcase
  endfunction

  initial begin
    int  st;
    bit  acc;
    int  sat_stalls;
    logic [31:0] cnt0;

    rst_n = 1'b0; inst_valid = 1'b0; inst_in = 32'h0;
    s_valid = 1'b0; s_in = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // RAW through fadd -> fmul
    cnt0 = stall_cnt;
    issue(FADD_3_1_2, st);
    chk("fadd_first_stalls", 64'(st), 64'h0);
    issue(FMUL_4_3_3, st);
    chk("fmul_raw_stalls", 64'(st), 64'(WIN));
    chk("fmul_stall_cnt_delta", 64'(stall_cnt - cnt0), 64'(WIN));
    idle(WB_LAT + 1);

    // independent back-to-back
    issue(FADD_3_1_2, st);
    issue(FADD_5_6_7, st);
    chk("indep_stalls", 64'(st), 64'h0);
    idle(1);
    chk("indep_second_out", 64'(inst_out), 64'(FADD_5_6_7));
    idle(WB_LAT + 1);

    // flw -> fsw on rs2, integer rs1 ignored
    issue(FLW_1, st);
    issue(FSW_1, st);
    chk("fsw_raw_stalls", 64'(st), 64'(WIN));
    idle(WB_LAT + 1);

    // fcvt.s.w then unrecognised OP-FP with matching fields
    issue(FCVTSW_1, st);
    issue(OPFP_BAD, st);
    chk("unrec_stalls", 64'(st), 64'h0);
    idle(1);
    chk("unrec_passthru", 64'(inst_out), 64'(OPFP_BAD));
    idle(WB_LAT + 1);
    chk("busy_drained", 64'(busy), 64'h0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), acc);
    end
    idle(WB_LAT + 1);

    // mid-stream reset with a writer in flight
    issue(FADD_3_1_2, st);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(FMUL_4_3_3, st);
    chk("post_reset_no_stall", 64'(st), 64'h0);
    idle(WB_LAT + 1);

    // saturation on the 3-bit counter instance: self-dependent fadd held valid
    sat_stalls = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_in    = FADD_3_3_3;
      #1;
      chk("sat_ready", 64'(s_ready), 64'((k % (WIN + 1)) == 0));
      chk("sat_cnt", 64'(s_cnt), 64'((sat_stalls > 7) ? 7 : sat_stalls));
      if ((k % (WIN + 1)) != 0) sat_stalls++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1 chk("sat_cnt_final", 64'(s_cnt), 64'h7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
